// File: rtl/ex_stage.sv
// Execute stage: ALU, signed-overflow detection and the EX/MEM register.
// Define EX_ITER_MUL_EN to add the iterative 32x32 MULU unit.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        int_detect,
    input  logic [29:0] id_pc,
    input  logic        id_en,
    input  logic [3:0]  id_alu_op,
    input  logic [31:0] id_alu_in_0,
    input  logic [31:0] id_alu_in_1,
    input  logic        id_br_flag,
    input  logic [1:0]  id_mem_op,
    input  logic [31:0] id_mem_wr_data,
    input  logic [1:0]  id_ctrl_op,
    input  logic [4:0]  id_dst_addr,
    input  logic        id_gpr_we_,
    input  logic [2:0]  id_exp_code,
    output logic [31:0] fwd_data,
    output logic        busy,
    output logic [29:0] ex_pc,
    output logic        ex_en,
    output logic        ex_br_flag,
    output logic [1:0]  ex_mem_op,
    output logic [31:0] ex_mem_wr_data,
    output logic [1:0]  ex_ctrl_op,
    output logic [4:0]  ex_dst_addr,
    output logic        ex_gpr_we_,
    output logic [2:0]  ex_exp_code,
    output logic [31:0] ex_out
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADDS = 4'h4;
    localparam logic [3:0] OP_ADDU = 4'h5;
    localparam logic [3:0] OP_SUBS = 4'h6;
    localparam logic [3:0] OP_SUBU = 4'h7;
    localparam logic [3:0] OP_SHRL = 4'h8;
    localparam logic [3:0] OP_SHLL = 4'h9;
    localparam logic [3:0] OP_MULU = 4'hA;

    localparam logic [2:0] EXP_NO  = 3'd0;
    localparam logic [2:0] EXP_OVF = 3'd3;

    typedef struct packed {
        logic [29:0] pc;
        logic        en;
        logic        br_flag;
        logic [1:0]  mem_op;
        logic [31:0] mem_wr_data;
        logic [1:0]  ctrl_op;
        logic [4:0]  dst_addr;
        logic        gpr_we_;
        logic [2:0]  exp_code;
        logic [31:0] out;
    } ex_reg_t;

    localparam ex_reg_t EX_RST = '{
        pc:          30'd0,
        en:          1'b0,
        br_flag:     1'b0,
        mem_op:      2'd0,
        mem_wr_data: 32'd0,
        ctrl_op:     2'd0,
        dst_addr:    5'd0,
        gpr_we_:     1'b1,
        exp_code:    3'd0,
        out:         32'd0
    };

    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_res;
    logic        ovf;
    logic        ovf_en;
    logic        squash;
    logic        mul_busy;
    logic        mul_done;
    logic [31:0] mul_res;
    ex_reg_t     ex_q;
    ex_reg_t     ex_d;

    assign a = id_alu_in_0;
    assign b = id_alu_in_1;

    always_comb begin
        alu_res = '0;
        ovf     = 1'b0;
        case (id_alu_op)
            OP_NOP:  alu_res = '0;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_ADDS: begin
                alu_res = a + b;
                ovf     = (a[31] == b[31]) && (alu_res[31] != a[31]);
            end
            OP_ADDU: alu_res = a + b;
            OP_SUBS: begin
                alu_res = a - b;
                ovf     = (a[31] != b[31]) && (alu_res[31] != a[31]);
            end
            OP_SUBU: alu_res = a - b;
            OP_SHRL: alu_res = a >> b[4:0];
            OP_SHLL: alu_res = a << b[4:0];
            OP_MULU: alu_res = '0;
            default: alu_res = '0;
        endcase
        // A finished product overrides whatever the ALU decoded.
        if (mul_done) begin
            alu_res = mul_res;
            ovf     = 1'b0;
        end
    end

    assign fwd_data = alu_res;
    assign ovf_en   = ovf & id_en;
    assign squash   = flush | (int_detect & (id_en | mul_done));

    always_comb begin
        ex_d = ex_q;
        if (stall) begin
            ex_d = ex_q;
        end else if (squash || busy) begin
            ex_d = EX_RST;
        end else begin
            ex_d.pc          = id_pc;
            ex_d.en          = id_en;
            ex_d.br_flag     = id_br_flag;
            ex_d.mem_op      = id_mem_op;
            ex_d.mem_wr_data = id_mem_wr_data;
            ex_d.ctrl_op     = id_ctrl_op;
            ex_d.dst_addr    = id_dst_addr;
            ex_d.out         = alu_res;
            ex_d.gpr_we_     = id_gpr_we_ | ovf_en;
            ex_d.exp_code    = (ovf_en && id_exp_code == EXP_NO)
                             ? EXP_OVF : id_exp_code;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q <= EX_RST;
        end else begin
            ex_q <= ex_d;
        end
    end

`ifdef EX_ITER_MUL_EN
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  st_q,     st_d;
    logic [5:0]  cnt_q,    cnt_d;
    logic [31:0] mcand_q,  mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] prod_q,   prod_d;
    logic        mul_start;
    logic        abort;

    assign abort     = flush | int_detect;
    assign mul_start = (st_q == ST_IDLE) && id_en
                    && (id_alu_op == OP_MULU) && !stall && !abort;

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        case (st_q)
            ST_IDLE: begin
                if (mul_start) begin
                    st_d     = ST_RUN;
                    cnt_d    = '0;
                    mcand_d  = a;
                    mplier_d = b;
                    prod_d   = '0;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    st_d = ST_IDLE;
                end else begin
                    // Shift-add: only the low 32 product bits are kept.
                    if (mplier_q[0]) prod_d = prod_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (abort || !stall) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q     <= ST_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            st_q     <= st_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

    assign mul_busy = mul_start || (st_q == ST_RUN);
    assign mul_done = (st_q == ST_DONE);
    assign mul_res  = prod_q;
`else
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    assign busy = mul_busy & ~reset;

    assign ex_pc          = ex_q.pc;
    assign ex_en          = ex_q.en;
    assign ex_br_flag     = ex_q.br_flag;
    assign ex_mem_op      = ex_q.mem_op;
    assign ex_mem_wr_data = ex_q.mem_wr_data;
    assign ex_ctrl_op     = ex_q.ctrl_op;
    assign ex_dst_addr    = ex_q.dst_addr;
    assign ex_gpr_we_     = ex_q.gpr_we_;
    assign ex_exp_code    = ex_q.exp_code;
    assign ex_out         = ex_q.out;

endmodule
